// File: rtl/feistel_cipher_core.sv
// Iterative ARX Feistel cipher, one round per clock; encrypt/decrypt per request.
// Optional CBC chaining (iv_in/iv_load ports and chain register) is enabled by defining FEISTEL_CBC_EN.
module feistel_cipher_core #(
    parameter int BLOCK_W = 64,
    parameter int KEY_W   = 64,
    parameter int ROUNDS  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               decrypt,
    input  logic [BLOCK_W-1:0] blk_in,
    input  logic [KEY_W-1:0]   key_in,
`ifdef FEISTEL_CBC_EN
    input  logic [BLOCK_W-1:0] iv_in,
    input  logic               iv_load,
`endif
    output logic [BLOCK_W-1:0] blk_out,
    output logic               busy,
    output logic               done,
    output logic               out_valid
);

    localparam int HALF = BLOCK_W / 2;
    localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state_q;
    logic [HALF-1:0]    l_q, r_q;
    logic [KEY_W-1:0]   key_q;
    logic               mode_q;
    logic [7:0]         rnd_q;
    logic [BLOCK_W-1:0] blk_out_q;
    logic               busy_q, done_q, out_valid_q;

    logic [7:0]         j_d;
    logic [31:0]        rot_d;
    logic [KEY_W-1:0]   key_rot_d;
    logic [HALF-1:0]    subkey_d, sum_d, f_d, r_next_d;
    logic               accept_d;
    logic [BLOCK_W-1:0] blk_src_d, result_d;

`ifdef FEISTEL_CBC_EN
    logic [BLOCK_W-1:0] chain_q, ct_q;
`endif

    // Decrypt walks the same subkey schedule backwards.
    always_comb begin
        j_d       = mode_q ? (LAST_RND - rnd_q) : rnd_q;
        rot_d     = (32'(j_d) * 32'd5) % 32'(KEY_W);
        key_rot_d = (key_q << rot_d) | (key_q >> (32'(KEY_W) - rot_d));
        subkey_d  = HALF'(key_rot_d ^ KEY_W'(j_d));
        sum_d     = r_q + subkey_d;
        f_d       = {sum_d[HALF-4:0], sum_d[HALF-1:HALF-3]} ^ (r_q >> 1);
        r_next_d  = l_q ^ f_d;
    end

    always_comb begin
`ifdef FEISTEL_CBC_EN
        accept_d  = start & ~iv_load;
        blk_src_d = decrypt ? blk_in : (blk_in ^ chain_q);
        result_d  = mode_q ? ({r_q, l_q} ^ chain_q) : {r_q, l_q};
`else
        accept_d  = start;
        blk_src_d = blk_in;
        result_d  = {r_q, l_q};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            key_q       <= '0;
            mode_q      <= 1'b0;
            rnd_q       <= '0;
            blk_out_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FEISTEL_CBC_EN
            chain_q     <= '0;
            ct_q        <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef FEISTEL_CBC_EN
                    if (iv_load) chain_q <= iv_in;
                    if (accept_d) ct_q <= blk_in;
`endif
                    if (accept_d) begin
                        l_q         <= blk_src_d[BLOCK_W-1:HALF];
                        r_q         <= blk_src_d[HALF-1:0];
                        key_q       <= key_in;
                        mode_q      <= decrypt;
                        rnd_q       <= '0;
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    l_q   <= r_q;
                    r_q   <= r_next_d;
                    rnd_q <= rnd_q + 8'd1;
                    if (rnd_q == LAST_RND) state_q <= FIN;
                end
                FIN: begin
                    // Halves are swapped back so encrypt and decrypt share one datapath.
                    blk_out_q   <= result_d;
                    done_q      <= 1'b1;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
`ifdef FEISTEL_CBC_EN
                    chain_q     <= mode_q ? ct_q : result_d;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign blk_out   = blk_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_feistel_cipher_core.sv
// Scoreboard bench for feistel_cipher_core: a 64/64/16 instance and a 32/48/5 instance
// checked against an arithmetic model of the cipher (CBC chaining tracked when FEISTEL_CBC_EN is defined).
module tb_feistel_cipher_core;

    typedef struct {
        logic [63:0] blk;
        int          edge_n;
    } exp_t;

    logic        clk, rst;
    int          cyc;
    int          n_chk, n_err;

    logic        start64, dec64, busy64, done64, ov64;
    logic [63:0] blk_in64, key_in64, blk_out64;
    logic        start32, dec32, busy32, done32, ov32;
    logic [31:0] blk_in32, blk_out32;
    logic [47:0] key_in32;
`ifdef FEISTEL_CBC_EN
    logic [63:0] iv_in64;
    logic [31:0] iv_in32;
    logic        iv_load64, iv_load32;
`endif
    logic [63:0] chain64_m;
    logic [31:0] chain32_m;

    exp_t q64[$];
    exp_t q32[$];
    exp_t e64, e32;

    feistel_cipher_core #(.BLOCK_W(64), .KEY_W(64), .ROUNDS(16)) u64 (
        .clk(clk), .rst(rst), .start(start64), .decrypt(dec64),
        .blk_in(blk_in64), .key_in(key_in64),
`ifdef FEISTEL_CBC_EN
        .iv_in(iv_in64), .iv_load(iv_load64),
`endif
        .blk_out(blk_out64), .busy(busy64), .done(done64), .out_valid(ov64)
    );

    feistel_cipher_core #(.BLOCK_W(32), .KEY_W(48), .ROUNDS(5)) u32 (
        .clk(clk), .rst(rst), .start(start32), .decrypt(dec32),
        .blk_in(blk_in32), .key_in(key_in32),
`ifdef FEISTEL_CBC_EN
        .iv_in(iv_in32), .iv_load(iv_load32),
`endif
        .blk_out(blk_out32), .busy(busy32), .done(done32), .out_valid(ov32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Cipher computed directly from the round equations on plain 64-bit integers.
    function automatic logic [63:0] model(input int bw, input int kw, input int rounds,
                                          input logic [63:0] blk, input logic [63:0] key,
                                          input bit dec);
        int          half;
        logic [63:0] hm, km, k0, l, r, rk, k, s, f, t;
        half = bw / 2;
        hm   = (64'd1 << half) - 64'd1;
        km   = (kw >= 64) ? '1 : ((64'd1 << kw) - 64'd1);
        k0   = key & km;
        l    = (blk >> half) & hm;
        r    = blk & hm;
        for (int i = 0; i < rounds; i++) begin
            int j, sh;
            j  = dec ? (rounds - 1 - i) : i;
            sh = (5 * j) % kw;
            rk = ((k0 << sh) | (k0 >> (kw - sh))) & km;
            k  = (rk ^ 64'(j)) & hm;
            s  = (r + k) & hm;
            f  = (((s << 3) | (s >> (half - 3))) & hm) ^ (r >> 1);
            t  = l ^ f;
            l  = r;
            r  = t;
        end
        return (r << half) | l;
    endfunction

    function automatic logic [63:0] predict64(input logic [63:0] blk, input logic [63:0] key, input bit dec);
        logic [63:0] res;
`ifdef FEISTEL_CBC_EN
        if (!dec) begin
            res = model(64, 64, 16, blk ^ chain64_m, key, 1'b0);
            chain64_m = res;
        end else begin
            res = model(64, 64, 16, blk, key, 1'b1) ^ chain64_m;
            chain64_m = blk;
        end
`else
        res = model(64, 64, 16, blk, key, dec);
`endif
        return res;
    endfunction

    function automatic logic [31:0] predict32(input logic [31:0] blk, input logic [47:0] key, input bit dec);
        logic [31:0] res;
`ifdef FEISTEL_CBC_EN
        if (!dec) begin
            res = 32'(model(32, 48, 5, 64'(blk ^ chain32_m), 64'(key), 1'b0));
            chain32_m = res;
        end else begin
            res = 32'(model(32, 48, 5, 64'(blk), 64'(key), 1'b1)) ^ chain32_m;
            chain32_m = blk;
        end
`else
        res = 32'(model(32, 48, 5, 64'(blk), 64'(key), dec));
`endif
        return res;
    endfunction

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done64) begin
            if (q64.size() == 0) begin
                chk("done64_unexpected", 64'd1, 64'd0);
            end else begin
                e64 = q64.pop_front();
                chk("blk_out64", blk_out64, e64.blk);
                chk("latency64", 64'(cyc), 64'(e64.edge_n + 17));
                chk("out_valid64_at_done", 64'(ov64), 64'd1);
                chk("busy64_at_done", 64'(busy64), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done32) begin
            if (q32.size() == 0) begin
                chk("done32_unexpected", 64'd1, 64'd0);
            end else begin
                e32 = q32.pop_front();
                chk("blk_out32", 64'(blk_out32), e32.blk);
                chk("latency32", 64'(cyc), 64'(e32.edge_n + 6));
            end
        end
    end

    task automatic issue64(input logic [63:0] blk, input logic [63:0] key, input bit dec,
                           input logic [63:0] exp, input bit push);
        int n = 0;
        while (busy64 && n < 200) begin @(posedge clk); #1; n++; end
        if (busy64) begin chk("issue64_timeout", 64'(busy64), 64'd0); return; end
        blk_in64 = blk; key_in64 = key; dec64 = dec; start64 = 1'b1;
        if (push) q64.push_back('{exp, cyc + 1});
        @(posedge clk); #1;
        start64 = 1'b0;
        chk("busy64_after_start", 64'(busy64), 64'd1);
        chk("out_valid64_after_start", 64'(ov64), 64'd0);
    endtask

    task automatic issue32(input logic [31:0] blk, input logic [47:0] key, input bit dec,
                           input logic [31:0] exp);
        int n = 0;
        while (busy32 && n < 100) begin @(posedge clk); #1; n++; end
        if (busy32) begin chk("issue32_timeout", 64'(busy32), 64'd0); return; end
        blk_in32 = blk; key_in32 = key; dec32 = dec; start32 = 1'b1;
        q32.push_back('{64'(exp), cyc + 1});
        @(posedge clk); #1;
        chk("busy32_after_start", 64'(busy32), 64'd1);
    endtask

    task automatic drain64();
        int n = 0;
        while ((q64.size() != 0 || busy64) && n < 200) begin @(posedge clk); #1; n++; end
        chk("drain64_pending", 64'(q64.size()), 64'd0);
    endtask

    task automatic drain32();
        int n = 0;
        while ((q32.size() != 0 || busy32) && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain32_pending", 64'(q32.size()), 64'd0);
    endtask

`ifdef FEISTEL_CBC_EN
    task automatic load_iv64(input logic [63:0] iv);
        int n = 0;
        while (busy64 && n < 200) begin @(posedge clk); #1; n++; end
        iv_in64 = iv; iv_load64 = 1'b1; start64 = 1'b1;
        @(posedge clk); #1;
        iv_load64 = 1'b0; start64 = 1'b0;
        chk("busy64_start_during_iv_load", 64'(busy64), 64'd0);
        chain64_m = iv;
    endtask

    task automatic load_iv32(input logic [31:0] iv);
        int n = 0;
        while (busy32 && n < 100) begin @(posedge clk); #1; n++; end
        iv_in32 = iv; iv_load32 = 1'b1;
        @(posedge clk); #1;
        iv_load32 = 1'b0;
        chain32_m = iv;
    endtask
`endif

    task automatic rt64(input logic [63:0] x, input logic [63:0] key);
        logic [63:0] c0, ct;
        c0 = chain64_m;
        ct = predict64(x, key, 1'b0);
        issue64(x, key, 1'b0, ct, 1'b1);
        drain64();
        repeat (3) @(posedge clk);
        #1;
        chk("out_valid64_held", 64'(ov64), 64'd1);
        chk("blk_out64_held", blk_out64, ct);
`ifdef FEISTEL_CBC_EN
        load_iv64(c0);
`endif
        issue64(ct, key, 1'b1, x, 1'b1);
        chain64_m = ct;
        drain64();
    endtask

    // start32 stays high throughout, so each IDLE cycle accepts the next request.
    task automatic rt32(input logic [31:0] x, input logic [47:0] key);
        logic [31:0] c0, ct;
        c0 = chain32_m;
        ct = predict32(x, key, 1'b0);
        issue32(x, key, 1'b0, ct);
`ifdef FEISTEL_CBC_EN
        load_iv32(c0);
`endif
        issue32(ct, key, 1'b1, x);
        chain32_m = ct;
    endtask

    initial begin
        logic [63:0] a, b, ca, cb, k;
        cyc = 0; n_chk = 0; n_err = 0;
        rst = 1'b1;
        start64 = 0; dec64 = 0; blk_in64 = '0; key_in64 = '0;
        start32 = 0; dec32 = 0; blk_in32 = '0; key_in32 = '0;
        chain64_m = '0; chain32_m = '0;
`ifdef FEISTEL_CBC_EN
        iv_in64 = '0; iv_in32 = '0; iv_load64 = 0; iv_load32 = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_blk_out64", blk_out64, 64'd0);
        chk("rst_busy64", 64'(busy64), 64'd0);
        chk("rst_done64", 64'(done64), 64'd0);
        chk("rst_out_valid64", 64'(ov64), 64'd0);
        chk("rst_blk_out32", 64'(blk_out32), 64'd0);
        chk("rst_out_valid32", 64'(ov32), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        rt64(64'h0123456789ABCDEF, 64'hAABB09182736CCDD);
        rt64(64'h0, 64'h0);
        rt64(64'hFFFFFFFFFFFFFFFF, 64'h0);

        // Start pulses while busy must be ignored; inputs change freely after acceptance.
        a = 64'h0123456789ABCDEF; b = 64'hDEADBEEFCAFEF00D; k = 64'h1357_9BDF_2468_ACE0;
        ca = predict64(a, k, 1'b0);
        issue64(a, k, 1'b0, ca, 1'b1);
        blk_in64 = b; key_in64 = ~k; dec64 = 1'b1;
        repeat (2) @(posedge clk);
        #1 start64 = 1'b1;
        @(posedge clk); #1 start64 = 1'b0;
        chk("busy64_ignore_a", 64'(busy64), 64'd1);
        repeat (6) @(posedge clk);
        #1 start64 = 1'b1;
        @(posedge clk); #1 start64 = 1'b0;
        chk("busy64_ignore_b", 64'(busy64), 64'd1);
        drain64();
        repeat (4) @(posedge clk);
        #1;
        chk("blk_out64_after_ignore", blk_out64, ca);
        cb = predict64(b, k, 1'b0);
        issue64(b, k, 1'b0, cb, 1'b1);
        drain64();

        // Mid-operation reset aborts with no done pulse.
        issue64(a, k, 1'b0, 64'd0, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_blk_out64", blk_out64, 64'd0);
        chk("midrst_busy64", 64'(busy64), 64'd0);
        chk("midrst_done64", 64'(done64), 64'd0);
        chk("midrst_out_valid64", 64'(ov64), 64'd0);
        chain64_m = '0; chain32_m = '0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_still_idle64", 64'(busy64), 64'd0);
        rt64(a, k);

        for (int i = 0; i < 20; i++)
            rt64({$urandom, $urandom}, {$urandom, $urandom});

        for (int i = 0; i < 1000; i++)
            rt32($urandom, {16'($urandom), $urandom});
        start32 = 1'b0;
        drain32();

`ifdef FEISTEL_CBC_EN
        a = 64'h0123456789ABCDEF; b = 64'hFEDCBA9876543210; k = 64'hAABB09182736CCDD;
        load_iv64(64'h1111111111111111);
        ca = model(64, 64, 16, a ^ 64'h1111111111111111, k, 1'b0);
        cb = model(64, 64, 16, b ^ ca, k, 1'b0);
        issue64(a, k, 1'b0, ca, 1'b1);
        issue64(b, k, 1'b0, cb, 1'b1);
        drain64();
        load_iv64(64'h1111111111111111);
        issue64(ca, k, 1'b1, a, 1'b1);
        issue64(cb, k, 1'b1, b, 1'b1);
        chain64_m = cb;
        drain64();
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("final_q64_empty", 64'(q64.size()), 64'd0);
        chk("final_q32_empty", 64'(q32.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/feistel_cipher_core.md
Name: feistel_cipher_core

Overview:
- Parametrised iterative Feistel block-cipher engine; successor to the fixed 64-bit encrypt-only blowfish core.
- Adds configurable block, key width and round count, a per-request encrypt/decrypt mode, a busy indication, and a held output-valid flag.
- One round per clock, shared datapath. Sits between the host-side request logic and the ciphertext sink.
- The F function is lightweight ARX (no S-box ROM), so it is bit-exactly modelable in the bench.

Parameters:
- BLOCK_W, 64: block width in bits. Must be even and ≥8. HALF = BLOCK_W/2.
- KEY_W, 64: key width in bits. Must be ≥ HALF.
- ROUNDS, 16: Feistel rounds. Range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe. Sampled only in IDLE.
- decrypt  in  1  mode for this request: 0 = encrypt, 1 = decrypt. Latched with start.
- blk_in  in  BLOCK_W  input block (plaintext or ciphertext).
- key_in  in  KEY_W  key. Latched with start.
- blk_out  out  BLOCK_W  result block.
- busy  out  1  high while rounds execute.
- done  out  1  single-cycle completion pulse.
- out_valid  out  1  blk_out holds a valid result.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - blk_out = 0, busy = 0, done = 0, out_valid = 0.
  - Round counter = 0; internal L/R/key/mode registers = 0.
- States:
  - IDLE: on start=1, latch L = blk_in[BLOCK_W-1:HALF], R = blk_in[HALF-1:0], key, mode. Set rnd = 0, busy = 1, out_valid = 0. Go to RUN.
  - RUN: one round per cycle. When rnd == ROUNDS-1, compute the final round and go to FIN.
  - FIN: blk_out = {R_n, L_n} (undo last swap), done = 1 for this single cycle, out_valid = 1, busy = 0. Return to IDLE.
- Subkey for round index j (j = rnd for encrypt, ROUNDS-1-rnd for decrypt):
  - K_j = rotl(key, (5*j) mod KEY_W)[HALF-1:0] XOR j, with j zero-extended to HALF bits.
- F(x, k) = rotl((x + k) mod 2^HALF, 3) XOR (x >> 1).
- Round update: L' = R; R' = L XOR F(R, K_j).
- Decrypt is the same datapath with subkeys in reverse order; for any key, decrypt(encrypt(x)) == x.
- Latency: start sampled high at edge N → busy high from N+1 → done high during cycle N+ROUNDS+1 (ROUNDS cycles in RUN, 1 in FIN). Throughput is one block per ROUNDS+2 cycles; next start accepted in the cycle after done.
- start high while busy: ignored; inputs are not re-latched, no error.
- start held high continuously: a new request is accepted in each IDLE cycle (back-to-back operation).
- blk_out and out_valid hold until the next accepted start, which clears out_valid in the following cycle.
- blk_in, key_in and decrypt may change freely after acceptance without affecting the result.
- rst asserted mid-operation: immediate abort to reset values; no done pulse.

Optional Feature:
- Macro FEISTEL_CBC_EN.
- When defined:
  - Adds ports iv_in (in, BLOCK_W) and iv_load (in, 1), plus a chain register reset to 0.
  - iv_load=1 in IDLE loads chain = iv_in; iv_load has priority over start in the same cycle, and start is ignored that cycle.
  - Encrypt: blk_in XOR chain is the cipher input; on FIN, chain = blk_out.
  - Decrypt: blk_out = raw_result XOR chain; on FIN, chain = the latched input ciphertext.
- When undefined: pure ECB with no extra ports; behaviour exactly as above.

Test Plan:
- ECB encrypt: BLOCK_W=64, ROUNDS=16, blk_in=0123456789ABCDEF, key=AABB09182736CCDD, start one cycle → done exactly 17 cycles after the start edge; blk_out equals the bench model; out_valid stays 1 afterwards.
- Round trip: feed that ciphertext with decrypt=1 and the same key → blk_out = 0123456789ABCDEF. Repeat for blk_in = 0 and FFFFFFFFFFFFFFFF with key = 0.
- Busy-ignore: pulse start with a second block at cycles +3 and +10 → first result unchanged; a single done pulse; second block processed only after a fresh start in IDLE.
- Mid-operation reset: assert rst at cycle +8 → all outputs 0 immediately, no done. A new request afterwards completes correctly in 17 cycles.
- Parametric: BLOCK_W=32, KEY_W=48, ROUNDS=5 with random vectors → done latency 6 cycles; encrypt/decrypt round-trip on 1000 vectors; results match the model.
- CBC (FEISTEL_CBC_EN): iv=1111…, encrypt blocks A, B → C1, C2 as per the model. Reload iv, decrypt C1, C2 → A, B.
